// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (CPOL=0, CPHA=0). An external host
// exchanges bytes with the CPU through this block. All SPI pins are
// oversampled in the clk domain, so clk must run at 8x or more the sclk rate.
//
// Ports:
//   clk, reset       system clock and synchronous active-high reset
//   spi_sclk/mosi    host clock and data (asynchronous, synchronised here)
//   spi_cs_n         host chip select, active low (asynchronous)
//   spi_miso         target-to-host data; spi_miso_oe enables the pad driver
//   rx_data/valid    last received byte (MSB first) and its one-cycle strobe
//   tx_data/valid    CPU write into the one-deep transmit holding register
//   tx_ready         holding register empty
//   tx_underrun      one-cycle strobe: FILL_BYTE was loaded for lack of data
//   selected         a frame is in progress
//   frame_end        one-cycle strobe when the host releases chip select
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       selected,
  output logic       frame_end
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchroniser chains plus one extra copy of sclk/cs_n for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic                   sclk_d_reg, cs_d_reg;
  // Marks which pipeline positions hold real pin samples since reset. Keeps
  // the idle reset value of cs_n from posing as a falling edge when the pin
  // is held low through reset.
  logic [SYNC_STAGES:0]   fill_reg;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       got_rise_reg, got_rise_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_full_reg, hold_full_next;
  logic       miso_reg, miso_next;
  logic       oe_reg, oe_next;
  logic       underrun_reg, underrun_next;
  logic       frame_end_reg, frame_end_next;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       load_now;
  logic [7:0] load_byte;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign cs_fall   = ~cs_s & cs_d_reg & fill_reg[SYNC_STAGES];
  assign cs_rise   = cs_s & ~cs_d_reg;
  assign load_byte = hold_full_reg ? hold_reg : FILL_BYTE;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b1;
      fill_reg      <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d_reg    <= sclk_s;
      cs_d_reg      <= cs_s;
      fill_reg      <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      got_rise_reg  <= 1'b0;
      rx_shift_reg  <= 8'h00;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      tx_shift_reg  <= 8'h00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
      miso_reg      <= 1'b1;
      oe_reg        <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      got_rise_reg  <= got_rise_next;
      rx_shift_reg  <= rx_shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      tx_shift_reg  <= tx_shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      miso_reg      <= miso_next;
      oe_reg        <= oe_next;
      underrun_reg  <= underrun_next;
      frame_end_reg <= frame_end_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    got_rise_next  = got_rise_reg;
    rx_shift_next  = rx_shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    tx_shift_next  = tx_shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    miso_next      = miso_reg;
    oe_next        = oe_reg;
    underrun_next  = 1'b0;
    frame_end_next = 1'b0;
    load_now       = 1'b0;

    case (state_reg)
      IDLE: begin
        // sclk activity is ignored until a frame starts
        if (cs_fall) begin
          state_next    = ACTIVE;
          load_now      = 1'b1;
          bit_cnt_next  = 3'd0;
          got_rise_next = 1'b0;
          oe_next       = 1'b1;
        end
      end
      ACTIVE: begin
        // Chip-select release wins over a coincident sclk edge, so a final
        // falling edge arriving with it does not trigger another byte load.
        if (cs_rise) begin
          state_next     = IDLE;
          oe_next        = 1'b0;
          miso_next      = 1'b1;
          bit_cnt_next   = 3'd0;
          got_rise_next  = 1'b0;
          rx_shift_next  = 8'h00;
          frame_end_next = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[6:0], mosi_s};
          bit_cnt_next  = bit_cnt_reg + 3'd1;   // 3-bit counter wraps 7 -> 0
          got_rise_next = 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            rx_data_next  = {rx_shift_reg[6:0], mosi_s};
            rx_valid_next = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_reg != 3'd0) begin
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            miso_next     = tx_shift_reg[6];
          end else if (got_rise_reg) begin
            load_now = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Byte load decides on the holding register contents before any
    // write in the same cycle, so a simultaneous write is kept for later.
    if (load_now) begin
      tx_shift_next = load_byte;
      miso_next     = load_byte[7];
      if (hold_full_reg) begin
        hold_full_next = 1'b0;
      end else begin
        underrun_next = 1'b1;
      end
    end

    if (tx_valid && !hold_full_reg) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end
  end

  assign spi_miso    = miso_reg;
  assign spi_miso_oe = oe_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_ready    = ~hold_full_reg;
  assign tx_underrun = underrun_reg;
  assign selected    = (state_reg == ACTIVE);
  assign frame_end   = frame_end_reg;

endmodule
